// File: rtl/gate_tt_checker.sv
// gate_tt_checker: exhaustive truth-table sweep/compare engine for small gate DUTs.
// Optional mismatch map output enabled by macro GATE_TT_CHECKER_MISMATCH_MAP_EN.
`default_nettype none

module gate_tt_checker #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   exp_tt_i,
  input  logic                 resp_i,
  output logic [N_IN-1:0]      stim_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [N_IN:0]        err_cnt_o,
  output logic [N_IN-1:0]      first_fail_o
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
  ,
  output logic [2**N_IN-1:0]   mismatch_map_o
`endif
);

  localparam int VECS = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With no settle time every vector goes straight to its sample cycle.
  localparam state_t         VEC_NEXT    = (SETTLE_CYC > 0) ? DRIVE : SAMPLE;
  localparam logic [7:0]     SETTLE_LAST = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [N_IN-1:0] LAST_VEC   = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE    = (N_IN + 1)'(1);

  state_t          state;
  logic [7:0]      cnt;
  logic [VECS-1:0] tt;
  logic            mismatch;

`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
  assign mismatch = (resp_i !== tt[stim_o]);
`else
  assign mismatch = resp_i ^ tt[stim_o];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tt           <= '0;
      stim_o       <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      err_cnt_o    <= '0;
      first_fail_o <= '0;
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
      mismatch_map_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            tt           <= exp_tt_i;
            err_cnt_o    <= '0;
            first_fail_o <= '0;
            pass_o       <= 1'b0;
            stim_o       <= '0;
            cnt          <= '0;
            busy_o       <= 1'b1;
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
            mismatch_map_o <= '0;
`endif
            state        <= VEC_NEXT;
          end
        end
        DRIVE: begin
          cnt <= cnt + 8'd1;
          if (cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_cnt_o <= err_cnt_o + ERR_ONE;
            if (err_cnt_o == '0) first_fail_o <= stim_o;
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
            mismatch_map_o[stim_o] <= 1'b1;
`endif
          end
          if (stim_o == LAST_VEC) begin
            state <= DONE;
          end else begin
            stim_o <= stim_o + STIM_ONE;
            cnt    <= '0;
            state  <= VEC_NEXT;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          pass_o <= (err_cnt_o == '0);
          stim_o <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench for gate_tt_checker: a 2-input/settle-1 and a 3-input/settle-0 instance.
`default_nettype none

module tb_gate_tt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       rst_n;
  // Instance A: N_IN=2, SETTLE_CYC=1
  logic       start;
  logic [3:0] exp_tt;
  logic [3:0] dut_tt;
  logic       resp;
  logic [1:0] stim;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] first_fail;
  // Instance B: N_IN=3, SETTLE_CYC=0
  logic       start3;
  logic [7:0] exp_tt3;
  logic [7:0] dut_tt3;
  logic       resp3;
  logic [2:0] stim3;
  logic       busy3, done3, pass3;
  logic [3:0] err_cnt3;
  logic [2:0] first_fail3;
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
  logic [3:0] map2;
  logic [7:0] map3;
`endif

  // Behavioural gate under test: its truth table indexed by the applied vector.
  assign resp  = dut_tt[stim];
  assign resp3 = dut_tt3[stim3];

  gate_tt_checker #(.N_IN(2), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .exp_tt_i(exp_tt), .resp_i(resp),
    .stim_o(stim), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .first_fail_o(first_fail)
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
    , .mismatch_map_o(map2)
`endif
  );

  gate_tt_checker #(.N_IN(3), .SETTLE_CYC(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .exp_tt_i(exp_tt3), .resp_i(resp3),
    .stim_o(stim3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
    .err_cnt_o(err_cnt3), .first_fail_o(first_fail3)
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
    , .mismatch_map_o(map3)
`endif
  );

  function automatic int popcount(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic int lowest_set(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  // Vector on the DUT c cycles after the start edge: each vector lasts per cycles.
  function automatic int exp_vec(input int c, input int per, input int last);
    return (c / per > last) ? last : c / per;
  endfunction

  // Full sweep on instance A with timing, ignored-start and result checks.
  task automatic sweep2(input logic [3:0] tt, input logic [3:0] dt, input bit disturb);
    int err_exp;
    err_exp = popcount({4'b0, tt ^ dt});
    @(negedge clk);
    exp_tt = tt; dut_tt = dt; start = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c <= 8) begin
        if (busy !== 1'b1 || done !== 1'b0 || stim !== 2'(exp_vec(c, 2, 3))) begin
          n_fail++;
          $display("FAIL sweep2_cycle%0d: busy=%b done=%b stim=%0d, required busy=1 done=0 stim=%0d",
                   c, busy, done, stim, exp_vec(c, 2, 3));
        end
      end else if (done !== 1'b1 || busy !== 1'b0 || stim !== 2'd0) begin
        n_fail++;
        $display("FAIL sweep2_done: done=%b busy=%b stim=%0d, required done=1 busy=0 stim=0",
                 done, busy, stim);
      end
      start = 1'b0;
      if (disturb && c == 2) begin start = 1'b1; exp_tt = 4'b1111; end
      if (disturb && c == 8) start = 1'b1;
    end
    n_cmp++;
    if (pass !== (err_exp == 0) || err_cnt !== 3'(err_exp) ||
        first_fail !== 2'(lowest_set({4'b0, tt ^ dt}))) begin
      n_fail++;
      $display("FAIL sweep2_result: pass=%b err=%0d ff=%0d, required pass=%b err=%0d ff=%0d",
               pass, err_cnt, first_fail, err_exp == 0, err_exp, lowest_set({4'b0, tt ^ dt}));
    end
`ifdef GATE_TT_CHECKER_MISMATCH_MAP_EN
    n_cmp++;
    if (map2 !== (tt ^ dt)) begin
      n_fail++;
      $display("FAIL sweep2_map: map=%b, required %b", map2, tt ^ dt);
    end
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== (err_exp == 0) || err_cnt !== 3'(err_exp)) begin
      n_fail++;
      $display("FAIL sweep2_hold: done=%b busy=%b pass=%b err=%0d, required 0 0 %b %0d",
               done, busy, pass, err_cnt, err_exp == 0, err_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0;
    exp_tt = '0; dut_tt = '0; exp_tt3 = '0; dut_tt3 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({stim, busy, done, pass, err_cnt, first_fail} !== '0 ||
        {stim3, busy3, done3, pass3, err_cnt3, first_fail3} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: A=%h B=%h, required 0",
               {stim, busy, done, pass, err_cnt, first_fail},
               {stim3, busy3, done3, pass3, err_cnt3, first_fail3});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nand2();   sweep2(4'b0111, 4'b0111, 1'b0); endtask
  task automatic test_and_fault(); sweep2(4'b0111, 4'b1000, 1'b0); endtask

  task automatic test_stuck1();
    sweep2(4'b0111, 4'b1111, 1'b0);
    n_cmp++;
    if (first_fail !== 2'd3 || err_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL stuck1: ff=%0d err=%0d, required ff=3 err=1", first_fail, err_cnt);
    end
  endtask

  task automatic test_restart_ignored(); sweep2(4'b0111, 4'b0110, 1'b1); endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] tt, dt;
      tt = 4'($urandom);
      dt = ($urandom_range(0, 3) == 0) ? tt : 4'($urandom);
      sweep2(tt, dt, 1'b0);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    exp_tt = 4'b0111; dut_tt = 4'b1000; start = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (err_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL abort_pre: err=%0d, required 2", err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stim, busy, done, pass, err_cnt, first_fail} !== '0) begin
      n_fail++;
      $display("FAIL abort_async: outputs=%h, required 0", {stim, busy, done, pass, err_cnt, first_fail});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_nodone: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    sweep2(4'b0111, 4'b0111, 1'b0);
  endtask

  task automatic test_settle0();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] tt, dt;
      int err_exp;
      tt = (i == 0) ? 8'b0111_1111 : 8'($urandom);
      dt = (i == 0) ? 8'b0111_1111 : (($urandom_range(0, 2) == 0) ? tt : 8'($urandom));
      err_exp = popcount(tt ^ dt);
      @(negedge clk);
      exp_tt3 = tt; dut_tt3 = dt; start3 = 1'b1;
      for (int c = 0; c <= 9; c++) begin
        @(negedge clk);
        start3 = 1'b0;
        n_cmp++;
        if (c <= 8) begin
          if (busy3 !== 1'b1 || done3 !== 1'b0 || stim3 !== 3'(exp_vec(c, 1, 7))) begin
            n_fail++;
            $display("FAIL settle0_cycle%0d: busy=%b done=%b stim=%0d, required 1 0 %0d",
                     c, busy3, done3, stim3, exp_vec(c, 1, 7));
          end
        end else if (done3 !== 1'b1 || busy3 !== 1'b0) begin
          n_fail++;
          $display("FAIL settle0_done: done=%b busy=%b, required 1 0", done3, busy3);
        end
      end
      n_cmp++;
      if (pass3 !== (err_exp == 0) || err_cnt3 !== 4'(err_exp) ||
          first_fail3 !== 3'(lowest_set(tt ^ dt))) begin
        n_fail++;
        $display("FAIL settle0_result: pass=%b err=%0d ff=%0d, required %b %0d %0d",
                 pass3, err_cnt3, first_fail3, err_exp == 0, err_exp, lowest_set(tt ^ dt));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nand2();
    test_and_fault();
    test_stuck1();
    test_restart_ignored();
    test_reset_abort();
    test_random();
    test_settle0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
